// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//     - lsu_state_t : FSM state encoding (IDLE / ACCESS / RESP)
//     - F3_*        : RV32I load/store funct3 codes
//     - lsu_size_t  : access size codes (byte / half / word)
//     - f3_size()   : funct3 -> access size (illegal codes fall back to word)
//     - f3_legal()  : funct3 legality for a load or a store
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Unsigned variants only exist for loads; for stores they are illegal
    // and therefore treated as word accesses.
    function automatic lsu_size_t f3_size(input logic store, input logic [2:0] f3);
        lsu_size_t sz;
        sz = SZ_W;
        case (f3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_BU:   sz = store ? SZ_W : SZ_B;
            F3_HU:   sz = store ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic for the load/store unit.
//   Optional feature macro: MISALIGN_TRAP_EN (enables the misalign flag).
//
//   Ports:
//     store     in   1   1 = store, 0 = load
//     funct3    in   3   RV32I funct3
//     addr_lo   in   2   byte offset within the word
//     wdata     in  32   raw store data (rs2)
//     rdata     in  32   raw memory read word
//     wmask     out  4   byte-lane write mask (0 for loads)
//     wdata_rep out 32   store data replicated across lanes
//     rdata_ext out 32   selected lane, sign/zero extended
//     misalign  out  1   misaligned or illegal access (0 when feature off)
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    lsu_size_t   size;
    logic        zext;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign size = f3_size(store, funct3);
    // funct3[2] marks the unsigned load variants (LBU/LHU).
    assign zext = funct3[2];

    always_comb begin
        rbyte     = rdata[7:0];
        rhalf     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        wmask     = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;

        case (addr_lo)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase

        case (size)
            SZ_B: begin
                wmask     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = zext ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            SZ_H: begin
                // addr_lo[0] is ignored: the half is picked by addr_lo[1].
                wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = zext ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            default: begin
                wmask     = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase

        if (!store) begin
            wmask = 4'b0000;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = ~f3_legal(store, funct3)
                    | ((size == SZ_H) & addr_lo[0])
                    | ((size == SZ_W) & (addr_lo != 2'd0));
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory-access stage after EXECUTE. Takes one load/store request, issues
//   one word access to data memory, and returns extended load data.
//   Optional feature macro: MISALIGN_TRAP_EN (misaligned/illegal accesses
//   skip memory and respond with resp_err = 1 one cycle after accept).
//
//   Handshakes: a request is accepted on a rising edge where req_valid and
//   req_ready are both high; the requester holds its fields stable until
//   then. A memory access completes on a rising edge where mem_req and
//   mem_ready are both high. resp_valid is a single-cycle pulse with no
//   backpressure.
//
//   Ports:
//     CLK, RESET                     clock, asynchronous active-low reset
//     req_valid/req_ready            request handshake
//     req_store/funct3/addr/wdata    request fields
//     resp_valid/resp_rdata/resp_err response (one-cycle pulse)
//     mem_req/we/addr/wmask/wdata    data memory request (held in ACCESS)
//     mem_rdata/mem_ready            data memory response
//     dbg_state                      current FSM state
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output lsu_state_t        dbg_state
);

    lsu_state_t        state, state_nxt;
    logic              accept;
    logic              sel_req;
    logic              a_store;
    logic [2:0]        a_funct3;
    logic [1:0]        a_lo;
    logic [3:0]        a_wmask;
    logic [31:0]       a_wdata;
    logic [31:0]       a_rdata;
    logic              misalign;

    logic              store_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lo_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wmask_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // RESET is folded in so req_ready is low throughout reset.
    assign req_ready = (state == ST_IDLE) && RESET;
    assign accept    = req_valid && req_ready;

    // One align instance serves both directions: in IDLE it sees the live
    // request (store lanes, misalign), in ACCESS the latched request
    // (load extraction of mem_rdata).
    assign sel_req  = (state == ST_IDLE);
    assign a_store  = sel_req ? req_store      : store_q;
    assign a_funct3 = sel_req ? req_funct3     : funct3_q;
    assign a_lo     = sel_req ? req_addr[1:0]  : lo_q;

    lsu_align u_align (
        .store     (a_store),
        .funct3    (a_funct3),
        .addr_lo   (a_lo),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .wmask     (a_wmask),
        .wdata_rep (a_wdata),
        .rdata_ext (a_rdata),
        .misalign  (misalign)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = misalign ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            lo_q     <= 2'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wmask_q  <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                lo_q     <= req_addr[1:0];
                we_q     <= req_store && !misalign;
                addr_q   <= req_addr[ADDR_W+1:2];
                wmask_q  <= misalign ? 4'd0 : a_wmask;
                wdata_q  <= a_wdata;
                rdata_q  <= 32'd0;
                err_q    <= misalign;
            end else if ((state == ST_ACCESS) && mem_ready) begin
                rdata_q <= store_q ? 32'd0 : a_rdata;
            end
        end
    end

    assign mem_req    = (state == ST_ACCESS);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wmask  = wmask_q;
    assign mem_wdata  = wdata_q;
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench for load_store_unit: directed cases plus randomized
//   requests against a byte-level reference model and a word memory model.
//   Honors MISALIGN_TRAP_EN when defined.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W = 8;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_store = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'd0;
    logic              mem_ready = 1'b0;
    lsu_state_t        dbg_state;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          waits;
        logic        err;
        logic [3:0]  mask;
        logic [31:0] mwd;
        logic [7:0]  widx;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] mem [256];
    logic [31:0] last_rdata;
    logic [3:0]  last_mask;
    logic [31:0] last_wdata;
    logic [7:0]  last_maddr;
    logic        last_we;

    // ---------------- reference model ----------------
    function automatic logic is_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int  bytes;
        logic legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        return (a % bytes) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: begin
                v = (w >> (8 * a[1:0])) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'h80) v = v - 32'h100;
            end
            3'b001, 3'b101: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic txn_t build(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input int waits);
        txn_t t;
        t.st = st; t.f3 = f3; t.addr = a; t.wd = wd; t.waits = waits;
        t.widx = a[9:2];
        t.err  = TRAP && is_bad(st, f3, a);
        t.mask = 4'd0;
        t.mwd  = wd;
        if (st) begin
            case (f3)
                3'b000: begin t.mask = 4'(1 << a[1:0]);       t.mwd = wd[7:0]  * 32'h01010101; end
                3'b001: begin t.mask = 4'(3 << (2 * a[1]));   t.mwd = wd[15:0] * 32'h00010001; end
                default: begin t.mask = 4'hF;                 t.mwd = wd;                      end
            endcase
        end
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input txn_t t);
        req_store  = t.st;
        req_funct3 = t.f3;
        req_addr   = t.addr;
        req_wdata  = t.wd;
        req_valid  = 1'b1;
    endtask

    // Called just after a falling edge; returns just after the accept edge.
    task automatic wait_accept();
        int g;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge CLK);
            g++;
        end
        check_eq("accept_timeout", 32'(g < 50), 32'd1);
        check_eq("resp_pulse_width", resp_valid, 1'b0);
        @(posedge CLK);
        #1;
    endtask

    // Serves memory for the oldest expected transaction and checks it.
    task automatic complete();
        txn_t        t;
        int          nreq, first, resp_c;
        logic [31:0] exp_rd;
        t      = exp_q.pop_front();
        nreq   = 0;
        first  = -1;
        resp_c = -1;
        exp_rd = (t.st || t.err) ? 32'd0 : model_load(t.f3, t.addr, mem[t.widx]);
        for (int c = 1; c <= 40 && resp_c < 0; c++) begin
            @(negedge CLK);
            check_eq("ready_while_busy", req_ready, 1'b0);
            if (mem_req) begin
                nreq++;
                if (first < 0) first = c;
                check_eq("mem_addr", 32'(mem_addr), 32'(t.widx));
                check_eq("mem_we", mem_we, t.st);
                check_eq("mem_wmask", 32'(mem_wmask), 32'(t.mask));
                if (t.st) check_eq("mem_wdata", mem_wdata, t.mwd);
                last_mask  = mem_wmask;
                last_wdata = mem_wdata;
                last_maddr = mem_addr;
                last_we    = mem_we;
                if (nreq == t.waits + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[t.widx];
                    if (t.st) begin
                        for (int i = 0; i < 4; i++)
                            if (t.mask[i]) mem[t.widx][8*i +: 8] = t.mwd[8*i +: 8];
                    end
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            if (resp_valid) begin
                resp_c     = c;
                last_rdata = resp_rdata;
                check_eq("resp_rdata", resp_rdata, exp_rd);
                check_eq("resp_err", resp_err, t.err);
            end
        end
        mem_ready = 1'b0;
        check_eq("resp_latency", 32'(resp_c), t.err ? 32'd1 : 32'(t.waits + 2));
        check_eq("mem_req_cycles", 32'(nreq), t.err ? 32'd0 : 32'(t.waits + 1));
        check_eq("mem_req_first", 32'(first), t.err ? 32'hFFFFFFFF : 32'd1);
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int waits);
        txn_t t;
        t = build(st, f3, a, wd, waits);
        @(negedge CLK);
        drive_req(t);
        exp_q.push_back(t);
        wait_accept();
        req_valid = 1'b0;
        complete();
    endtask

    // Second request is presented while the first is still in flight.
    task automatic run_pair(input txn_t t1, input txn_t t2);
        @(negedge CLK);
        drive_req(t1);
        exp_q.push_back(t1);
        wait_accept();
        drive_req(t2);
        exp_q.push_back(t2);
        complete();
        wait_accept();
        req_valid = 1'b0;
        complete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        txn_t ta, tb;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Reset state, with a request pending that must not be seen.
        req_valid = 1'b1;
        repeat (2) @(negedge CLK);
        check_eq("rst_req_ready", req_ready, 1'b0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_outs", {mem_we, mem_wmask, resp_err}, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        req_valid = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;

        // Lane extraction vectors.
        mem[4] = 32'h80FF7F01;
        run_req(1'b0, F3_B, 32'h13, 32'd0, 0);
        check_eq("lb_value", last_rdata, 32'hFFFFFF80);
        check_eq("lb_mem_addr", 32'(last_maddr), 32'd4);
        check_eq("lb_mem_we", last_we, 1'b0);
        run_req(1'b0, F3_BU, 32'h13, 32'd0, 0);
        check_eq("lbu_value", last_rdata, 32'h00000080);
        run_req(1'b0, F3_HU, 32'h12, 32'd0, 1);
        check_eq("lhu_value", last_rdata, 32'h000080FF);
        run_req(1'b0, F3_H, 32'h12, 32'd0, 0);
        check_eq("lh_value", last_rdata, 32'hFFFF80FF);

        // Store halfword lanes.
        run_req(1'b1, F3_H, 32'h22, 32'h1234ABCD, 0);
        check_eq("sh_mask", 32'(last_mask), 32'hC);
        check_eq("sh_wdata", last_wdata, 32'hABCDABCD);
        check_eq("sh_mem_addr", 32'(last_maddr), 32'd8);
        check_eq("sh_rdata", last_rdata, 32'd0);

        // Timing: zero-wait and three-wait accesses.
        run_req(1'b0, F3_W, 32'h0, 32'd0, 0);
        run_req(1'b0, F3_W, 32'h0, 32'd0, 3);

        // Misaligned word load.
        run_req(1'b0, F3_W, 32'h6, 32'd0, 0);

        // Back-to-back: store then load to the same word, ordering preserved.
        ta = build(1'b1, F3_B, 32'h41, 32'h000000A5, 1);
        tb = build(1'b0, F3_BU, 32'h41, 32'd0, 0);
        run_pair(ta, tb);
        check_eq("b2b_load_after_store", last_rdata, 32'h000000A5);

        // Reset in the middle of an access.
        ta = build(1'b0, F3_W, 32'h40, 32'd0, 0);
        @(negedge CLK);
        drive_req(ta);
        wait_accept();
        req_valid = 1'b0;
        mem_ready = 1'b0;
        @(negedge CLK);
        check_eq("abort_pre_mem_req", mem_req, 1'b1);
        #2 RESET = 1'b0;
        #1;
        check_eq("abort_mem_req", mem_req, 1'b0);
        check_eq("abort_req_ready", req_ready, 1'b0);
        check_eq("abort_resp_valid", resp_valid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check_eq("abort_no_resp", resp_valid, 1'b0);
            check_eq("abort_no_mem_req", mem_req, 1'b0);
        end
        RESET = 1'b1;
        run_req(1'b1, F3_W, 32'h4, 32'hDEADBEEF, 1);
        run_req(1'b0, F3_W, 32'h4, 32'd0, 0);
        check_eq("post_reset_sw_readback", last_rdata, 32'hDEADBEEF);

        // Randomized traffic, including illegal funct3 and misaligned offsets.
        for (int n = 0; n < 80; n++) begin
            if (n % 5 == 4) begin
                ta = build(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                           $urandom, $urandom, $urandom_range(0, 3));
                tb = build(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                           $urandom, $urandom, $urandom_range(0, 3));
                run_pair(ta, tb);
            end else begin
                run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        $urandom, $urandom, $urandom_range(0, 3));
            end
        end

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
